// File: rtl/seq_mode_alu.sv
// -----------------------------------------------------------------------------
// seq_mode_alu
//
// Multi-cycle, handshaked mode-select ALU. One request is taken on the
// valid/ready input channel, and one result is returned on the valid/ready
// output channel. Only one transaction is in flight at a time.
//
// Modes (in_mode):
//   2'b00 : ((a + b) << 1)              1 cycle
//   2'b10 : (a << 4) | (b >> 2)         1 cycle
//   2'b11 : ~(a ^ b) + 1                1 cycle
//   2'b01 : (a - b) / DIVISOR           WIDTH + 1 cycles (restoring divider)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   request ready (high only while idle and out of reset)
//   in_mode    operation select
//   in_a/in_b  operands
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer ready
//   out_data   result (keeps its last value after the handshake)
// -----------------------------------------------------------------------------
module seq_mode_alu #(
    parameter int          WIDTH   = 32,
    parameter int unsigned DIVISOR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] DIVISOR_C = (WIDTH + 1)'(DIVISOR);
    localparam logic [CW-1:0]  CNT_INIT  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;  // dividend shifts out MSB-first; quotient bits shift in at LSB
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             accept_s;
    logic [WIDTH:0]   rem_shift_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] quot_next_s;

    // Request is only taken in IDLE; in_ready is held low while rst is asserted.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // One restoring-division step: bring in the next dividend bit, then trial-subtract.
    // The remainder never exceeds DIVISOR-1 after a step, so the WIDTH+1-bit
    // truncation of {rem, bit} loses nothing.
    always_comb begin
        rem_shift_s = (WIDTH + 1)'({rem_q, dividend_q[WIDTH-1]});
        q_bit_s     = (rem_shift_s >= DIVISOR_C);
        quot_next_s = {dividend_q[WIDTH-2:0], q_bit_s};
    end

    // Next-state, datapath and output register inputs.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (in_mode)
                        2'b00: begin
                            out_data_d  = (in_a + in_b) << 1;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                        2'b10: begin
                            out_data_d  = (in_a << 4) | (in_b >> 2);
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                        2'b11: begin
                            out_data_d  = ~(in_a ^ in_b) + {{(WIDTH-1){1'b0}}, 1'b1};
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                        2'b01: begin
                            dividend_d = in_a - in_b;
                            rem_d      = '0;
                            cnt_d      = CNT_INIT;
                            state_d    = DIV;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            DIV: begin
                if (q_bit_s) begin
                    rem_d = rem_shift_s - DIVISOR_C;
                end else begin
                    rem_d = rem_shift_s;
                end
                dividend_d = quot_next_s;
                if (cnt_q == {CW{1'b0}}) begin
                    out_data_d  = quot_next_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_seq_mode_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_mode_alu
//
// Directed testbench for seq_mode_alu at default parameters (WIDTH=32,
// DIVISOR=3). Expected values are hand-computed constants. Latency is counted
// in rising edges, with the accepting edge counted as 1.
// -----------------------------------------------------------------------------
module tb_seq_mode_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_tests;
    int n_fail;

    seq_mode_alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, drive one request, and return after the accepting edge.
    task automatic send_req(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        check_val({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Full transaction: send, measure latency, check result, then handshake.
    task automatic run_req(input string tag, input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit rdy_seen;
        send_req(tag, m, a, b);
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_data"}, out_data, exp);
        check_val({tag, "_busy"}, 32'(rdy_seen), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
        check_val({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        check_val({tag, "_hold"}, out_data, exp);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_a      = 32'd5;
        in_b      = 32'd7;
        out_ready = 1'b0;

        // Reset with a request held valid: nothing may be accepted.
        repeat (3) tick();
        check_val("rst_vld", 32'(out_valid), 32'd0);
        check_val("rst_data", out_data, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_val("rst_ready", 32'(in_ready), 32'd1);
        tick();
        check_val("rst_noacc", 32'(out_valid), 32'd0);
        check_val("rst_noacc_rdy", 32'(in_ready), 32'd1);

        // Single-cycle modes
        run_req("add",    2'b00, 32'd5, 32'd7, 32'd24, 1);
        run_req("shf",    2'b10, 32'd1, 32'h10, 32'h14, 1);
        run_req("neg",    2'b11, 32'd3, 32'd5, 32'hFFFF_FFFA, 1);
        run_req("neg_eq", 2'b11, 32'hF, 32'hF, 32'h0, 1);

        // Divider
        run_req("div",      2'b01, 32'd100, 32'd10, 32'd30, 33);
        run_req("div_wrap", 2'b01, 32'd0, 32'd1, 32'h5555_5555, 33);
        run_req("div_zero", 2'b01, 32'd7, 32'd7, 32'd0, 33);

        // Backpressure: result held, changing requests ignored.
        send_req("bp", 2'b00, 32'd10, 32'd20);
        check_val("bp_vld", 32'(out_valid), 32'd1);
        check_val("bp_data", out_data, 32'd60);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'(i);
            in_a     = 32'(i * 13 + 1);
            in_b     = 32'(i * 7 + 3);
            tick();
            check_val($sformatf("bp_hold%0d", i), out_data, 32'd60);
            check_val($sformatf("bp_vld%0d", i), 32'(out_valid), 32'd1);
            check_val($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
        end
        in_mode   = 2'b10;
        in_a      = 32'd1;
        in_b      = 32'h10;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_hs_vld", 32'(out_valid), 32'd0);
        check_val("bp_hs_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("bp_next_vld", 32'(out_valid), 32'd1);
        check_val("bp_next_data", out_data, 32'h14);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_next_clr", 32'(out_valid), 32'd0);

        // Reset in the middle of a division
        send_req("abort", 2'b01, 32'd100, 32'd10);
        repeat (10) tick();
        check_val("abort_busy", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check_val("abort_vld", 32'(out_valid), 32'd0);
        check_val("abort_data", out_data, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_val("abort_rdy", 32'(in_ready), 32'd1);
        tick();
        check_val("abort_nores", 32'(out_valid), 32'd0);
        run_req("after_abort", 2'b01, 32'd9, 32'd0, 32'd3, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (tests run %0d)", n_tests);
        $fatal(1, "timeout");
    end

endmodule
